// File: rtl/wash_pkg.sv
// Shared definitions for the washer program sequencer and its front-panel helpers.
// Holds the phase encodings, the cycle-count bounds, the 50 MHz timing constants,
// and the program-select to cycle-count mapping.
package wash_pkg;

    localparam int unsigned PHASE_W         = 3;
    localparam int unsigned TIMER_W         = 31;
    localparam int unsigned PROG_MAX_CYCLES = 4;
    localparam int unsigned CYCLES_W        = $clog2(PROG_MAX_CYCLES + 1);

    // Phase codes double as the LED encoding.
    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_ARM   = 3'd1;
    localparam logic [2:0] PH_RUN   = 3'd2;
    localparam logic [2:0] PH_GAP   = 3'd3;
    localparam logic [2:0] PH_DONE  = 3'd4;
    localparam logic [2:0] PH_FAULT = 3'd5;

    // Timing at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_50M = 500_000;        // 10 ms
    localparam int unsigned ACK_CYCLES_50M      = 16;
    localparam int unsigned GAP_CYCLES_50M      = 50_000_000;     // 1 s
    localparam int unsigned TIMEOUT_CYCLES_50M  = 1_500_000_000;  // 30 s

    // Number of wash cycles a program select value asks for.
    function automatic logic [CYCLES_W-1:0] prog_to_cycles(input logic [1:0] prog_sel);
        return CYCLES_W'(prog_sel) + CYCLES_W'(1);
    endfunction

endpackage

// File: rtl/start_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a registered
// one-clock pulse on the debounced rising edge. The pulse appears
// DEBOUNCE_CYCLES+3 clocks after the raw input rises.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   btn_async     - raw push-button, asynchronous to clk
//   start_p       - one-clock pulse per accepted press
module start_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_async,
    output logic start_p
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             pulse_q, pulse_d;

    // The debounced level only follows the synchronized input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        sync1_d      = btn_async;
        sync2_d      = sync1_q;
        cnt_d        = '0;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        pulse_d      = stable_q & ~stable_dly_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            pulse_q      <= pulse_d;
        end
    end

    assign start_p = pulse_q;

endmodule

// File: rtl/wash_program_sequencer.sv
// Program-level controller above the washer FSM. Runs 1-4 wash cycles back to
// back: pulses fsm_start, waits for fsm_ready to fall and rise again, inserts a
// settle gap between cycles. Watchdogs the ack and the cycle, interlocks on the
// door and holds the washer in reset while faulted.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start_btn           - raw start push-button
//   prog_sel[1:0]       - program select, cycle count = prog_sel+1
//   door_closed         - door interlock, 1 = closed
//   fsm_ready           - washer FSM ready
//   fsm_start           - washer start request (high throughout ARM)
//   fsm_abort           - washer FSM reset (high in FAULT)
//   busy, done, fault   - status; done and fault are sticky
//   cycles_left[2:0]    - remaining cycles including the current one
//   phase[2:0]          - current phase code for LEDs
module wash_program_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
    parameter int unsigned ACK_CYCLES      = ACK_CYCLES_50M,
    parameter int unsigned GAP_CYCLES      = GAP_CYCLES_50M,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_50M
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_btn,
    input  logic [1:0]          prog_sel,
    input  logic                door_closed,
    input  logic                fsm_ready,
    output logic                fsm_start,
    output logic                fsm_abort,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [CYCLES_W-1:0] cycles_left,
    output logic [PHASE_W-1:0]  phase
);

    logic                start_p;
    logic [PHASE_W-1:0]  state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CYCLES_W-1:0] cycles_left_q, cycles_left_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                fsm_start_q, fsm_start_d;
    logic                busy_q, busy_d;
    logic                active_c;

    start_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_async(start_btn),
        .start_p  (start_p)
    );

    assign active_c = (state_q == PH_ARM) || (state_q == PH_RUN) || (state_q == PH_GAP);

    // Next state; within the running phases: door open > watchdog > normal exit.
    always_comb begin
        state_d       = state_q;
        cycles_left_d = cycles_left_q;
        done_d        = done_q;
        timer_d       = '0;
        case (state_q)
            PH_IDLE: begin
                if (start_p && door_closed && fsm_ready) begin
                    state_d       = PH_ARM;
                    cycles_left_d = prog_to_cycles(prog_sel);
                    done_d        = 1'b0;
                end
            end
            PH_ARM: begin
                if (!door_closed) begin
                    state_d = PH_FAULT;
                end else if (timer_q == TIMER_W'(ACK_CYCLES - 1)) begin
                    state_d = PH_FAULT;
                end else if (!fsm_ready) begin
                    state_d = PH_RUN;
                end
            end
            PH_RUN: begin
                if (!door_closed) begin
                    state_d = PH_FAULT;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = PH_FAULT;
                end else if (fsm_ready) begin
                    cycles_left_d = cycles_left_q - CYCLES_W'(1);
                    if (cycles_left_q == CYCLES_W'(1)) begin
                        state_d = PH_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PH_GAP;
                    end
                end
            end
            PH_GAP: begin
                if (!door_closed) begin
                    state_d = PH_FAULT;
                end else if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
                    state_d = PH_ARM;
                end
            end
            PH_DONE: begin
                state_d = PH_IDLE;
            end
            PH_FAULT: begin
                if (start_p && door_closed) begin
                    state_d = PH_IDLE;
                end
            end
            default: begin
                state_d = PH_FAULT;
            end
        endcase

        // Timer only runs while staying in a running phase; any change clears it.
        if (active_c && (state_d == state_q)) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        // Outputs are decoded from the next state so they line up with phase.
        fsm_start_d = (state_d == PH_ARM);
        busy_d      = (state_d == PH_ARM) || (state_d == PH_RUN) || (state_d == PH_GAP);
        fault_d     = (state_d == PH_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= PH_IDLE;
            timer_q       <= '0;
            cycles_left_q <= '0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fsm_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cycles_left_q <= cycles_left_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fsm_start_q   <= fsm_start_d;
            busy_q        <= busy_d;
        end
    end

    assign fsm_start   = fsm_start_q;
    assign fsm_abort   = fault_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign cycles_left = cycles_left_q;
    assign phase       = state_q;

endmodule
